// File: rtl/axi_crossbar_m_arb_if.sv
// Request/grant and write-select bundle between one crossbar master port's
// address arbiter and its requesting slave interfaces.
interface axi_crossbar_m_arb_if #(
  parameter int unsigned S_COUNT = 4
);
  localparam int unsigned SEL_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

  logic [S_COUNT-1:0]   req;
  logic [S_COUNT*4-1:0] req_qos;
  logic                 ack;
  logic [S_COUNT-1:0]   grant;
  logic                 grant_valid;
  logic [SEL_W-1:0]     grant_encoded;
  logic [SEL_W-1:0]     wsel;
  logic                 wsel_valid;
  logic                 wsel_ready;

  // Arbiter side
  modport master (
    input  req, req_qos, ack, wsel_ready,
    output grant, grant_valid, grant_encoded, wsel, wsel_valid
  );

  // Requester / W-mux side
  modport slave (
    output req, req_qos, ack, wsel_ready,
    input  grant, grant_valid, grant_encoded, wsel, wsel_valid
  );
endinterface

// File: rtl/axi_crossbar_m_arb.sv
// Round-robin address arbiter for one crossbar master port with a write-select FIFO.
// Optional QoS-first winner selection when AXI_CROSSBAR_ARB_QOS_EN is defined.
module axi_crossbar_m_arb #(
  parameter int unsigned S_COUNT      = 4,
  parameter int unsigned W_FIFO_DEPTH = 4,
  parameter bit          W_FIFO_EN    = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  axi_crossbar_m_arb_if.master arb
);
  localparam int unsigned SEL_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
  localparam int unsigned PTR_W = $clog2(W_FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(W_FIFO_DEPTH + 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [S_COUNT-1:0] grant_q, grant_d;
  logic               grant_valid_q, grant_valid_d;
  logic [SEL_W-1:0]   grant_enc_q, grant_enc_d;
  logic [SEL_W-1:0]   last_q, last_d;

  logic [SEL_W-1:0]   fifo_mem_q [W_FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic               push_c, pop_c, full_c, empty_c;
  logic [S_COUNT-1:0] cand_c;
  logic               win_found_c;
  logic [SEL_W-1:0]   win_idx_c;

  // Candidate set: all requesters, or only those at the highest active QoS
`ifdef AXI_CROSSBAR_ARB_QOS_EN
  logic [3:0] max_qos_c;

  always_comb begin
    max_qos_c = 4'd0;
    cand_c    = '0;
    for (int unsigned n = 0; n < S_COUNT; n++) begin
      if (arb.req[n] && (arb.req_qos[n*4 +: 4] > max_qos_c)) begin
        max_qos_c = arb.req_qos[n*4 +: 4];
      end
    end
    for (int unsigned n = 0; n < S_COUNT; n++) begin
      cand_c[n] = arb.req[n] && (arb.req_qos[n*4 +: 4] == max_qos_c);
    end
  end
`else
  logic unused_qos_c;

  assign unused_qos_c = ^arb.req_qos;
  assign cand_c       = arb.req;
`endif

  // First candidate strictly after the last acknowledged winner, wrapping
  always_comb begin
    int unsigned idx;
    idx         = 0;
    win_found_c = 1'b0;
    win_idx_c   = '0;
    for (int unsigned k = 1; k <= S_COUNT; k++) begin
      idx = 32'(last_q) + k;
      if (idx >= S_COUNT) begin
        idx = idx - S_COUNT;
      end
      if (!win_found_c && cand_c[SEL_W'(idx)]) begin
        win_found_c = 1'b1;
        win_idx_c   = SEL_W'(idx);
      end
    end
  end

  assign empty_c = (count_q == '0);
  assign full_c  = W_FIFO_EN && (count_q == CNT_W'(W_FIFO_DEPTH));
  assign pop_c   = W_FIFO_EN && arb.wsel_ready && !empty_c;

  // Grant FSM: next state and registered grant outputs
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_enc_d   = grant_enc_q;
    last_d        = last_q;
    push_c        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found_c && !full_c) begin
          state_d       = ST_GRANTED;
          grant_valid_d = 1'b1;
          grant_enc_d   = win_idx_c;
          grant_d       = S_COUNT'(1) << win_idx_c;
        end
      end
      ST_GRANTED: begin
        if (arb.ack) begin
          state_d       = ST_IDLE;
          grant_valid_d = 1'b0;
          grant_d       = '0;
          last_d        = grant_enc_q;
          push_c        = W_FIFO_EN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_enc_q   <= '0;
      last_q        <= SEL_W'(S_COUNT - 1);
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_enc_q   <= grant_enc_d;
      last_q        <= last_d;
    end
  end

  // Write-select FIFO; a grant is only issued when not full, so a push always fits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < W_FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      if (push_c) begin
        fifo_mem_q[wr_ptr_q] <= grant_enc_q;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push_c && !pop_c) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!push_c && pop_c) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  assign arb.grant         = grant_q;
  assign arb.grant_valid   = grant_valid_q;
  assign arb.grant_encoded = grant_enc_q;
  assign arb.wsel          = W_FIFO_EN ? fifo_mem_q[rd_ptr_q] : '0;
  assign arb.wsel_valid    = W_FIFO_EN && !empty_c;

endmodule

// File: tb/tb_axi_crossbar_m_arb.sv
// Randomized bench for axi_crossbar_m_arb against a queue-based arbitration model.
module tb_axi_crossbar_m_arb;
  localparam int unsigned S     = 4;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  axi_crossbar_m_arb_if #(.S_COUNT(S)) bus ();

  axi_crossbar_m_arb #(
    .S_COUNT     (S),
    .W_FIFO_DEPTH(DEPTH),
    .W_FIFO_EN   (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arb(bus)
  );

  int    n_checks = 0;
  int    n_pass   = 0;
  string phase    = "init";

  // Model: one outstanding grant plus an ordered list of acknowledged winners
  bit m_busy;
  int m_gidx;
  int m_last;
  int m_q[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int pick(logic [S-1:0] r, logic [S*4-1:0] qos, int last);
    logic [S-1:0] elig;
    int           best;
    best = 0;
    elig = r;
`ifdef AXI_CROSSBAR_ARB_QOS_EN
    for (int n = 0; n < S; n++)
      if (r[n] && int'(qos[n*4 +: 4]) > best) best = int'(qos[n*4 +: 4]);
    for (int n = 0; n < S; n++)
      elig[n] = r[n] && (int'(qos[n*4 +: 4]) == best);
`else
    if (qos === 'x) best = 0;
`endif
    for (int k = 1; k <= S; k++)
      if (elig[(last + k) % S]) return (last + k) % S;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_gidx = 0;
    m_last = S - 1;
    m_q.delete();
  endtask

  task automatic model_step();
    bit pop, full, push;
    int w, pv;
    pop  = bus.wsel_ready && (m_q.size() != 0);
    full = (m_q.size() == DEPTH);
    push = 1'b0;
    pv   = 0;
    if (m_busy) begin
      if (bus.ack) begin
        push   = 1'b1;
        pv     = m_gidx;
        m_last = m_gidx;
        m_busy = 1'b0;
      end
    end else if (!full) begin
      w = pick(bus.req, bus.req_qos, m_last);
      if (w >= 0) begin
        m_busy = 1'b1;
        m_gidx = w;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(pv);
  endtask

  task automatic check_outputs();
    check({phase, ".gvalid"}, 32'(bus.grant_valid), 32'(m_busy));
    if (m_busy) begin
      check({phase, ".grant"}, 32'(bus.grant), 32'(1) << m_gidx);
      check({phase, ".genc"}, 32'(bus.grant_encoded), 32'(m_gidx));
    end
    check({phase, ".wvalid"}, 32'(bus.wsel_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check({phase, ".wsel"}, 32'(bus.wsel), 32'(m_q[0]));
  endtask

  // Drive inputs at the falling edge, let the model and DUT advance, check at next falling edge
  task automatic cycle(logic [S-1:0] r, logic [S*4-1:0] q, logic a, logic wr);
    bus.req        = r;
    bus.req_qos    = q;
    bus.ack        = a;
    bus.wsel_ready = wr;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    bus.req        = '0;
    bus.req_qos    = '0;
    bus.ack        = 1'b0;
    bus.wsel_ready = 1'b0;
    rst            = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst.gvalid", 32'(bus.grant_valid), 32'd0);
    check("rst.grant", 32'(bus.grant), 32'd0);
    check("rst.genc", 32'(bus.grant_encoded), 32'd0);
    check("rst.wvalid", 32'(bus.wsel_valid), 32'd0);
    check("rst.wsel", 32'(bus.wsel), 32'd0);
    rst = 1'b0;
  endtask

  task automatic drain();
    repeat (12) cycle('0, '0, bus.grant_valid, 1'b1);
  endtask

  initial begin
    int gseq[$];
    int wseq[$];
    int exp_rr[5];
    int exp_qos[3];
    exp_rr = '{0, 1, 2, 3, 0};
`ifdef AXI_CROSSBAR_ARB_QOS_EN
    exp_qos = '{3, 1, 3};
`else
    exp_qos = '{3, 0, 1};
`endif
    @(negedge clk);
    do_reset();

    // All requesting, immediate acks and pops: order 0,1,2,3,0 on both grant and wsel
    phase = "rr";
    for (int i = 0; i < 14; i++) begin
      if (bus.grant_valid) gseq.push_back(int'(bus.grant_encoded));
      if (bus.wsel_valid)  wseq.push_back(int'(bus.wsel));
      cycle(4'b1111, '0, bus.grant_valid, bus.wsel_valid);
    end
    check("rr.ngrants", 32'(gseq.size() >= 5), 32'd1);
    check("rr.npops", 32'(wseq.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < gseq.size()) check("rr.gseq", 32'(gseq[i]), 32'(exp_rr[i]));
      if (i < wseq.size()) check("rr.wseq", 32'(wseq[i]), 32'(exp_rr[i]));
    end
    drain();

    // Grant held after request withdrawal, released only by ack
    phase = "hold";
    cycle(4'b0100, '0, 1'b0, 1'b0);
    repeat (3) cycle(4'b0000, '0, 1'b0, 1'b0);
    check("hold.grant", 32'(bus.grant), 32'h4);
    cycle(4'b0000, '0, 1'b1, 1'b0);
    check("hold.fall", 32'(bus.grant_valid), 32'd0);
    drain();

    // Full FIFO blocks the fifth grant until one entry is popped
    phase = "full";
    repeat (12) cycle(4'b1111, '0, bus.grant_valid, 1'b0);
    check("full.blocked", 32'(bus.grant_valid), 32'd0);
    cycle(4'b1111, '0, 1'b0, 1'b1);
    check("full.still_blocked", 32'(bus.grant_valid), 32'd0);
    cycle(4'b1111, '0, 1'b0, 1'b0);
    check("full.regrant", 32'(bus.grant_valid), 32'd1);
    cycle(4'b0000, '0, 1'b1, 1'b0);
    drain();

    // QoS-weighted versus pure round-robin order from last winner 1
    phase = "qos";
    do_reset();
    cycle(4'b0010, '0, 1'b0, 1'b0);
    cycle(4'b0000, '0, 1'b1, 1'b1);
    gseq.delete();
    for (int i = 0; i < 8; i++) begin
      if (bus.grant_valid) gseq.push_back(int'(bus.grant_encoded));
      cycle(4'b1011, 16'h7071, bus.grant_valid, 1'b1);
    end
    check("qos.ngrants", 32'(gseq.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++)
      if (i < gseq.size()) check("qos.gseq", 32'(gseq[i]), 32'(exp_qos[i]));
    drain();

    // Asynchronous reset in the middle of a grant with two queued entries
    phase = "midrst";
    repeat (5) cycle(4'b1111, '0, bus.grant_valid, 1'b0);
    check("midrst.pre_gvalid", 32'(bus.grant_valid), 32'd1);
    check("midrst.pre_wvalid", 32'(bus.wsel_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst.gvalid", 32'(bus.grant_valid), 32'd0);
    check("midrst.wvalid", 32'(bus.wsel_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(4'b1000, '0, 1'b0, 1'b0);
    check("midrst.regrant", 32'(bus.grant_encoded), 32'd3);
    cycle(4'b0000, '0, 1'b1, 1'b0);

    // Random traffic: slow drain first to exercise full, then fast drain
    phase = "rand";
    for (int i = 0; i < 3000; i++) begin
      logic a, wr;
      if (bus.grant_valid) a = ($urandom_range(0, 1) == 1);
      else                 a = ($urandom_range(0, 7) == 0);
      if (i < 1500) wr = ($urandom_range(0, 4) == 0);
      else          wr = ($urandom_range(0, 9) < 7);
      cycle(S'($urandom), 16'($urandom) & 16'h3333, a, wr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
